jesd204_tx_char_replace: RTL and testbench
==========================================

// Module: jesd204_tx_char_replace
// PURPOSE
//  Per-lane TX alignment-character insertion stage for non-scrambled links (JESD204B 5.3.3.4).
//  Consumes the eof/eomf octet markers from the frame-mark generator plus one lane of user octets.
//  Replaces a frame's final octet with /F/ (K28.7, 0xFC) or /A/ (K28.3, 0x7C) when it repeats the
//  previous frame's final octet. Sits between the TX lane data mux and the 8b/10b/PHY interface.
// PARAMETERS
//  DATA_PATH_WIDTH  8  octets per beat; octet i = data[8*i+7:8*i], i=0 first on wire
// PORTS
//  clk                          in   1         link clock
//  resetn                       in   1         asynchronous active-low reset
//  cfg_disable_char_replacement in   1         1: bypass, no replacement (scrambling on / test)
//  in_data_phase                in   1         1: link in DATA phase; 0: CGS/ILAS passthrough
//  in_data                      in   8*DPW     lane octets
//  in_charisk                   in   DPW       per-octet K flag of in_data
//  eof                          in   DPW       octet i is last octet of a frame
//  eomf                         in   DPW       octet i is last octet of a multiframe (implies eof)
//  out_data                     out  8*DPW     lane octets after replacement
//  out_charisk                  out  DPW       per-octet K flag after replacement
// BEHAVIOUR
//  Reset (async, resetn=0): out_data=0, out_charisk=0, prev_valid=0, prev_last=8'h00, prev_repl=0.
//  Latency: exactly 1 clk, in -> out; all outputs registered; no backpressure, one beat every cycle.
//  State: prev_last (orig final octet of last frame), prev_repl (it was replaced with /F/ or /A/),
//   prev_valid (a DATA-phase frame end has been seen since entry to DATA).
//  in_data_phase=0 or cfg_disable_char_replacement=1: out=in (data and charisk) unchanged;
//   prev_valid<=0 and prev_repl<=0; markers ignored.
//  DATA phase, per octet i with eof[i]=1, evaluated in order i=0..DPW-1 within the beat:
//   ref = original octet of nearest lower j<i with eof[j]=1 in this beat, else prev_last;
//   rv = that frame's repl flag (same beat chain), else prev_repl; pv = 1 if j found, else prev_valid.
//   match = pv & (in_data octet i == ref) & ~in_charisk[i].
//   eomf[i] & match            -> octet := 8'h7C, charisk[i]:=1, repl:=1   (/A/)
//   ~eomf[i] & match & ~rv     -> octet := 8'hFC, charisk[i]:=1, repl:=1   (/F/)
//   otherwise                  -> octet unchanged, repl:=0.
//  Comparison always uses ORIGINAL (pre-replacement) octets, never the substituted K char.
//  Non-eof octets pass through unchanged.
//  End of beat: if any eof[i], prev_last<=orig octet at highest such i, prev_repl<=its repl,
//   prev_valid<=1; else state held.
//  Multiple eof per beat (octets/frame < DPW) chain combinationally; octets/frame > DPW carries
//   across beats via state.
//  First frame after entering DATA phase never replaced (prev_valid=0).
//  Entry to DATA phase mid-beat is not supported; in_data_phase changes on beat boundaries only.
//  resetn asserted mid-stream: outputs and state clear asynchronously; first post-reset frame
//   is not replaced.
// TESTING (DPW=4, 4 octets/frame, 2 frames/multiframe unless noted)
//  1. Reset: resetn=0 with random inputs -> out_data=0, out_charisk=0; release -> out tracks in
//     after 1 clk.
//  2. Frames ending 0x11,0x11 (2nd not eomf) -> 2nd frame last octet 0xFC, charisk=1;
//     1st unchanged.
//  3. Frames ending 0x22,0x22,0x22 (no eomf) -> /F/ on 2nd only, 3rd passes 0x22 (prev_repl);
//     4th 0x22 -> /F/.
//  4. Frame ending 0x33 then eomf frame ending 0x33 -> 0x7C, charisk=1; even if prev was /F/ -> /A/.
//  5. DPW=4, 1 octet/frame, in=0x55,0x55,0x55,0x55 eof=4'hF eomf=0 after a prior 0x55 frame ->
//     out FC,55,FC,55.
//  6. cfg_disable_char_replacement=1 or in_data_phase=0 with repeating finals -> out==in delayed
//     1 clk; first frame after returning to DATA unchanged.

Source files
------------

// File: rtl/jesd204_tx_char_replace.sv
// Per-lane TX alignment-character insertion for non-scrambled JESD204B links.
// A frame's final octet becomes /F/ (0xFC) or /A/ (0x7C) when it repeats the previous frame's final octet.
module jesd204_tx_char_replace #(
    parameter int DATA_PATH_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cfg_disable_char_replacement,
    input  logic                         in_data_phase,
    input  logic [8*DATA_PATH_WIDTH-1:0] in_data,
    input  logic [DATA_PATH_WIDTH-1:0]   in_charisk,
    input  logic [DATA_PATH_WIDTH-1:0]   eof,
    input  logic [DATA_PATH_WIDTH-1:0]   eomf,
    output logic [8*DATA_PATH_WIDTH-1:0] out_data,
    output logic [DATA_PATH_WIDTH-1:0]   out_charisk
);

    localparam int DPW = DATA_PATH_WIDTH;

    logic [7:0]         prev_last_reg, prev_last_next;
    logic               prev_repl_reg, prev_repl_next;
    logic               prev_valid_reg, prev_valid_next;
    logic [8*DPW-1:0]   data_next;
    logic [DPW-1:0]     charisk_next;

    logic               active;
    logic [7:0]         ref_last;
    logic               ref_repl;
    logic               ref_valid;
    logic [7:0]         octet;
    logic               match;
    logic               repl;

    assign active = in_data_phase & ~cfg_disable_char_replacement;

    // The reference walks through the beat octet by octet, so several frame ends
    // in one beat each compare against the original final octet of the frame before.
    always_comb begin
        ref_last     = prev_last_reg;
        ref_repl     = prev_repl_reg;
        ref_valid    = prev_valid_reg;
        data_next    = in_data;
        charisk_next = in_charisk;
        octet        = 8'h00;
        match        = 1'b0;
        repl         = 1'b0;
        for (int i = 0; i < DPW; i++) begin
            octet = in_data[8*i +: 8];
            match = 1'b0;
            repl  = 1'b0;
            if (active && eof[i]) begin
                match = ref_valid && (octet == ref_last) && !in_charisk[i];
                if (match && eomf[i]) begin
                    data_next[8*i +: 8] = 8'h7C;
                    charisk_next[i]     = 1'b1;
                    repl                = 1'b1;
                end else if (match && !ref_repl) begin
                    data_next[8*i +: 8] = 8'hFC;
                    charisk_next[i]     = 1'b1;
                    repl                = 1'b1;
                end
                ref_last  = octet;
                ref_repl  = repl;
                ref_valid = 1'b1;
            end
        end

        if (active) begin
            prev_last_next  = ref_last;
            prev_repl_next  = ref_repl;
            prev_valid_next = ref_valid;
        end else begin
            prev_last_next  = prev_last_reg;
            prev_repl_next  = 1'b0;
            prev_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data       <= '0;
            out_charisk    <= '0;
            prev_last_reg  <= 8'h00;
            prev_repl_reg  <= 1'b0;
            prev_valid_reg <= 1'b0;
        end else begin
            out_data       <= data_next;
            out_charisk    <= charisk_next;
            prev_last_reg  <= prev_last_next;
            prev_repl_reg  <= prev_repl_next;
            prev_valid_reg <= prev_valid_next;
        end
    end

endmodule

// File: tb/tb_jesd204_tx_char_replace.sv
// Bench for jesd204_tx_char_replace with four octets per beat: directed frame scenarios
// plus randomized beats checked against a frame-level reference model.
module tb_jesd204_tx_char_replace;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_disable_char_replacement = 1'b0;
    logic        in_data_phase = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_charisk = '0;
    logic [3:0]  eof = '0;
    logic [3:0]  eomf = '0;
    logic [31:0] out_data;
    logic [3:0]  out_charisk;

    int checks = 0;
    int failures = 0;

    // Reference model state: final octet of the last frame seen in DATA phase.
    logic [7:0] mdl_last;
    logic       mdl_repl;
    logic       mdl_valid;

    jesd204_tx_char_replace #(.DATA_PATH_WIDTH(4)) dut (
        .clk                          (clk),
        .resetn                       (resetn),
        .cfg_disable_char_replacement (cfg_disable_char_replacement),
        .in_data_phase                (in_data_phase),
        .in_data                      (in_data),
        .in_charisk                   (in_charisk),
        .eof                          (eof),
        .eomf                         (eomf),
        .out_data                     (out_data),
        .out_charisk                  (out_charisk)
    );

    always #5 clk = ~clk;

    // Drive one beat of plain data octets, then sample just after the capturing edge.
    task automatic beat(input logic [31:0] d, input logic [3:0] e, input logic [3:0] m);
        in_data    = d;
        in_charisk = 4'h0;
        eof        = e;
        eomf       = m;
        @(posedge clk);
        #1;
    endtask

    // One passthrough beat so the next DATA-phase frame starts with no history.
    task automatic idle_beat();
        in_data_phase = 1'b0;
        cfg_disable_char_replacement = 1'b0;
        beat($urandom, 4'h8, 4'h0);
        in_data_phase = 1'b1;
    endtask

    // Each frame's final octet is compared with the previous frame's original final octet.
    task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e,
                              input logic [3:0] m, input logic ph, input logic dis,
                              output logic [31:0] od, output logic [3:0] ok);
        logic [7:0] b;
        logic       rep;
        od = d;
        ok = k;
        if (!ph || dis) begin
            mdl_valid = 1'b0;
            mdl_repl  = 1'b0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (e[i]) begin
                b   = d[8*i +: 8];
                rep = 1'b0;
                if (mdl_valid && b == mdl_last && !k[i]) begin
                    if (m[i]) begin
                        od[8*i +: 8] = 8'h7C; ok[i] = 1'b1; rep = 1'b1;
                    end else if (!mdl_repl) begin
                        od[8*i +: 8] = 8'hFC; ok[i] = 1'b1; rep = 1'b1;
                    end
                end
                mdl_last  = b;
                mdl_repl  = rep;
                mdl_valid = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        resetn = 1'b0;
        for (int n = 0; n < 3; n++) begin
            in_data_phase = 1'b1;
            in_data = $urandom; in_charisk = 4'($urandom); eof = 4'($urandom); eomf = 4'h0;
            @(posedge clk); #1;
            checks++;
            if (out_data !== 32'h0 || out_charisk !== 4'h0) begin
                failures++;
                $display("FAIL reset_out: data=%h k=%h required data=00000000 k=0", out_data, out_charisk);
            end
        end
        resetn = 1'b1;
        in_data_phase = 1'b0;
        d = $urandom;
        in_data = d; in_charisk = 4'h5; eof = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (out_data !== d || out_charisk !== 4'h5) begin
            failures++;
            $display("FAIL reset_release: data=%h k=%h required data=%h k=5", out_data, out_charisk, d);
        end
    endtask

    task automatic test_f_basic();
        idle_beat();
        beat(32'h11A1B2C3, 4'h8, 4'h0);
        checks++;
        if (out_data !== 32'h11A1B2C3 || out_charisk !== 4'h0) begin
            failures++;
            $display("FAIL f_basic_first: data=%h k=%h required data=11a1b2c3 k=0", out_data, out_charisk);
        end
        beat(32'h11040506, 4'h8, 4'h0);
        checks++;
        if (out_data !== 32'hFC040506 || out_charisk !== 4'h8) begin
            failures++;
            $display("FAIL f_basic_second: data=%h k=%h required data=fc040506 k=8", out_data, out_charisk);
        end
    endtask

    task automatic test_f_repeat();
        logic [7:0] exp_last [4];
        exp_last = '{8'h22, 8'hFC, 8'h22, 8'hFC};
        idle_beat();
        for (int n = 0; n < 4; n++) begin
            beat({8'h22, 24'(n * 3 + 1)}, 4'h8, 4'h0);
            checks++;
            if (out_data !== {exp_last[n], 24'(n * 3 + 1)} || out_charisk !== {exp_last[n] == 8'hFC, 3'b000}) begin
                failures++;
                $display("FAIL f_repeat_%0d: data=%h k=%h required last=%h", n, out_data, out_charisk, exp_last[n]);
            end
        end
    endtask

    task automatic test_a_char();
        idle_beat();
        beat(32'h33000001, 4'h8, 4'h0);
        beat(32'h33000002, 4'h8, 4'h8);
        checks++;
        if (out_data !== 32'h7C000002 || out_charisk !== 4'h8) begin
            failures++;
            $display("FAIL a_basic: data=%h k=%h required data=7c000002 k=8", out_data, out_charisk);
        end
        idle_beat();
        beat(32'h33000003, 4'h8, 4'h0);
        beat(32'h33000004, 4'h8, 4'h0);
        checks++;
        if (out_data !== 32'hFC000004 || out_charisk !== 4'h8) begin
            failures++;
            $display("FAIL a_pre_f: data=%h k=%h required data=fc000004 k=8", out_data, out_charisk);
        end
        beat(32'h33000005, 4'h8, 4'h8);
        checks++;
        if (out_data !== 32'h7C000005 || out_charisk !== 4'h8) begin
            failures++;
            $display("FAIL a_after_f: data=%h k=%h required data=7c000005 k=8", out_data, out_charisk);
        end
    endtask

    task automatic test_multi_eof();
        idle_beat();
        beat(32'h55010203, 4'h8, 4'h0);
        beat(32'h55555555, 4'hF, 4'h0);
        checks++;
        if (out_data !== 32'h55FC55FC || out_charisk !== 4'h5) begin
            failures++;
            $display("FAIL multi_eof: data=%h k=%h required data=55fc55fc k=5", out_data, out_charisk);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] d;
        idle_beat();
        for (int n = 0; n < 4; n++) begin
            cfg_disable_char_replacement = (n < 2);
            in_data_phase = (n < 2);
            d = {8'h66, 24'($urandom)};
            beat(d, 4'h8, 4'(n[0]) << 3);
            checks++;
            if (out_data !== d || out_charisk !== 4'h0) begin
                failures++;
                $display("FAIL bypass_%0d: data=%h k=%h required data=%h k=0", n, out_data, out_charisk, d);
            end
        end
        cfg_disable_char_replacement = 1'b0;
        in_data_phase = 1'b1;
        beat(32'h66000010, 4'h8, 4'h0);
        checks++;
        if (out_data !== 32'h66000010 || out_charisk !== 4'h0) begin
            failures++;
            $display("FAIL bypass_reentry: data=%h k=%h required data=66000010 k=0", out_data, out_charisk);
        end
        beat(32'h66000011, 4'h8, 4'h0);
        checks++;
        if (out_data !== 32'hFC000011 || out_charisk !== 4'h8) begin
            failures++;
            $display("FAIL bypass_second: data=%h k=%h required data=fc000011 k=8", out_data, out_charisk);
        end
    endtask

    task automatic test_midstream_reset();
        idle_beat();
        beat(32'h44000001, 4'h8, 4'h0);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (out_data !== 32'h0 || out_charisk !== 4'h0) begin
            failures++;
            $display("FAIL async_reset: data=%h k=%h required data=00000000 k=0", out_data, out_charisk);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        beat(32'h44000002, 4'h8, 4'h0);
        checks++;
        if (out_data !== 32'h44000002 || out_charisk !== 4'h0) begin
            failures++;
            $display("FAIL post_reset_first: data=%h k=%h required data=44000002 k=0", out_data, out_charisk);
        end
        beat(32'h44000003, 4'h8, 4'h0);
        checks++;
        if (out_data !== 32'hFC000003 || out_charisk !== 4'h8) begin
            failures++;
            $display("FAIL post_reset_second: data=%h k=%h required data=fc000003 k=8", out_data, out_charisk);
        end
    endtask

    task automatic test_random();
        logic [7:0]  alphabet [3];
        logic [31:0] d, exp_d;
        logic [3:0]  k, e, m, exp_k;
        logic        ph, dis;
        alphabet = '{8'h11, 8'h22, 8'hFC};
        mdl_valid = 1'b0;
        mdl_repl  = 1'b0;
        mdl_last  = 8'h00;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                d[8*i +: 8] = alphabet[$urandom_range(0, 2)];
                k[i] = ($urandom_range(0, 7) == 0);
            end
            e   = 4'($urandom);
            m   = e & 4'($urandom);
            ph  = (n == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
            dis = ($urandom_range(0, 19) == 0);
            model_beat(d, k, e, m, ph, dis, exp_d, exp_k);
            in_data = d; in_charisk = k; eof = e; eomf = m;
            in_data_phase = ph; cfg_disable_char_replacement = dis;
            @(posedge clk); #1;
            checks++;
            if (out_data !== exp_d || out_charisk !== exp_k) begin
                failures++;
                $display("FAIL random_%0d: in=%h k=%h eof=%h eomf=%h got data=%h k=%h required data=%h k=%h",
                         n, d, k, e, m, out_data, out_charisk, exp_d, exp_k);
            end
        end
        cfg_disable_char_replacement = 1'b0;
    endtask

    initial begin
        test_reset();
        test_f_basic();
        test_f_repeat();
        test_a_char();
        test_multi_eof();
        test_bypass();
        test_midstream_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
